nco_sin_gen: RTL and testbench
==============================

NCO_SIN_GEN -- requirements
Module: nco_sin_gen

Interface
REQ-001 Parameter PHASE_RES, default 24: phase accumulator width in bits.
REQ-002 Parameter LUT_ADDR_W, default 8: quarter-wave table address width; PHASE_RES SHALL be >= LUT_ADDR_W+2.
REQ-003 Parameter SIN_SIZE, default 13: output width in sign-magnitude (MSB = sign, SIN_SIZE-1 magnitude bits).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  sample strobe; one accumulator step and one output sample per cycle en=1.
REQ-007 fcw  input  PHASE_RES  frequency control word, captured on fcw_ld.
REQ-008 fcw_ld  input  1  load fcw into the internal fcw register.
REQ-009 phase_clr  input  1  force the phase of the current step to zero.
REQ-010 sin_out  output  SIN_SIZE  registered sine sample, sign-magnitude.
REQ-011 cos_out  output  SIN_SIZE  registered cosine sample; present only under COS_OUT_EN.
REQ-012 out_valid  output  1  high for exactly one cycle per accepted en.

Function
REQ-013 Cycle with en=1: sample phase p = phase_clr ? 0 : acc; acc <= p + fcw_reg, modulo 2^PHASE_RES (wrap, no saturation).
REQ-014 en=0: acc holds; phase_clr alone SHALL set acc <= 0.
REQ-015 fcw_ld=1: fcw_reg <= fcw; the new value SHALL take effect at the first en cycle after the load cycle; with simultaneous en, the step in the load cycle uses the old fcw_reg.
REQ-016 Truncated index k = top LUT_ADDR_W+2 bits of p; quadrant q = top 2 bits of k, i = low LUT_ADDR_W bits.
REQ-017 Table address: i for q=0,2; 2^LUT_ADDR_W - i for q=1,3 (LUT_ADDR_W+1 bit address).
REQ-018 Table entry j (0..2^LUT_ADDR_W inclusive) SHALL be round((2^(SIN_SIZE-1)-1) * sin(pi/2 * j / 2^LUT_ADDR_W)).
REQ-019 Sign bit = 1 for q=2,3; a zero magnitude SHALL always be emitted with sign 0 (no negative zero).
REQ-020 Pipeline: 3 register stages (fold/address, table read, sign apply); sin_out and out_valid for the sample taken at cycle n SHALL update at the edge ending cycle n+3.
REQ-021 out_valid SHALL be the en strobe delayed 3 cycles; sin_out/cos_out SHALL hold their last value while out_valid=0.
REQ-022 Back-to-back en SHALL sustain one sample per cycle, no bubbles.

Reset
REQ-023 rst=1: acc=0, fcw_reg=0, all pipeline valid bits 0, sin_out=0, cos_out=0, out_valid=0.
REQ-024 rst SHALL override en, fcw_ld and phase_clr in the same cycle; in-flight samples are discarded and no out_valid follows them.
REQ-025 First en after rst release SHALL produce phase 0 (sin_out=0).

Configuration
REQ-026 Macro COS_OUT_EN defined: cos_out port exists, computed as REQ-016..REQ-019 with q replaced by q+1 (mod 4), same latency, aligned with sin_out.
REQ-027 COS_OUT_EN undefined: cos_out port, second table read and cosine pipeline SHALL be absent; sin_out behaviour is unchanged.

Structure
REQ-028 Default widths (`phaseRes`, `SinSize`) and quadrant encodings SHALL live in the shared bleDefines.v; parameter defaults derive from them.
REQ-029 Quarter-wave table SHALL be a sub-module sin_quarter_rom (registered read, one port, two under COS_OUT_EN).

Verification (PHASE_RES=3, LUT_ADDR_W=1, SIN_SIZE=13 unless stated)
REQ-030 rst, fcw_ld fcw=1, en held 8 cycles -> sin_out 0x0000,0x0B50,0x0FFF,0x0B50,0x0000,0x1B50,0x1FFF,0x1B50, first out_valid 3 cycles after first en.
REQ-031 fcw=3, 8 en cycles -> sequence wraps mod 8: phases 0,3,6,1,4,7,2,5; sin_out 0x0000,0x0B50,0x1FFF,0x0B50,0x0000,0x1B50,0x0FFF,0x1B50.
REQ-032 phase_clr with en at phase 5 -> that sample's sin_out 0x0000, next sample phase = fcw_reg.
REQ-033 fcw_ld (2->1) same cycle as en, then en -> step uses 2, subsequent steps use 1; en gaps -> out_valid gaps identical, outputs held.
REQ-034 rst asserted with 2 samples in flight -> out_valid stays 0, all outputs 0 next cycle.
REQ-035 COS_OUT_EN, fcw=2 -> cos_out 0x0FFF,0x0000,0x1FFF,0x0000 aligned with sin_out 0x0000,0x0FFF,0x0000,0x1FFF.

Source files
------------

// File: rtl/nco_sin_gen_pkg.sv
// rtl/nco_sin_gen_pkg.sv - shared default widths and quadrant encodings for the sine NCO
package nco_sin_gen_pkg;

  localparam int PHASE_RES_DEF  = 24;
  localparam int LUT_ADDR_W_DEF = 8;
  localparam int SIN_SIZE_DEF   = 13;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  // Second half of the period carries a negative sign.
  function automatic logic quad_negative(quad_e q);
    return (q == QUAD_2) || (q == QUAD_3);
  endfunction

  // Odd quadrants walk the quarter-wave table backwards.
  function automatic logic quad_mirrored(quad_e q);
    return (q == QUAD_1) || (q == QUAD_3);
  endfunction

endpackage

// File: rtl/sin_quarter_rom.sv
// rtl/sin_quarter_rom.sv - registered quarter-wave sine table, 2^LUT_ADDR_W+1 entries
// Second read port exists only when COS_OUT_EN is defined.
module sin_quarter_rom
  import nco_sin_gen_pkg::*;
#(
  parameter int LUT_ADDR_W = LUT_ADDR_W_DEF,
  parameter int MAG_W      = SIN_SIZE_DEF - 1
) (
  input  logic                  clk,
  input  logic [LUT_ADDR_W:0]   addr_a,
  output logic [MAG_W-1:0]      data_a
`ifdef COS_OUT_EN
  ,
  input  logic [LUT_ADDR_W:0]   addr_b,
  output logic [MAG_W-1:0]      data_b
`endif
);

  localparam int  DEPTH      = 1 << LUT_ADDR_W;
  localparam real HALF_PI    = 1.5707963267948966;
  localparam real FULL_SCALE = real'((1 << MAG_W) - 1);

  logic [MAG_W-1:0] rom_w [0:DEPTH];

  // Entries are elaborated constants: rounded full-scale sine over [0, pi/2].
  for (genvar j = 0; j <= DEPTH; j++) begin : g_tab
    localparam real ANGLE = HALF_PI * real'(j) / real'(DEPTH);
    localparam int  VAL   = $rtoi(FULL_SCALE * $sin(ANGLE) + 0.5);
    assign rom_w[j] = VAL[MAG_W-1:0];
  end

  always_ff @(posedge clk) begin
    data_a <= rom_w[addr_a];
  end

`ifdef COS_OUT_EN
  always_ff @(posedge clk) begin
    data_b <= rom_w[addr_b];
  end
`endif

endmodule

// File: rtl/nco_sin_gen.sv
// rtl/nco_sin_gen.sv - phase-accumulator NCO with quarter-wave sine lookup, 3-stage pipeline
// Optional cosine output enabled by defining COS_OUT_EN.
module nco_sin_gen
  import nco_sin_gen_pkg::*;
#(
  parameter int PHASE_RES  = PHASE_RES_DEF,
  parameter int LUT_ADDR_W = LUT_ADDR_W_DEF,
  parameter int SIN_SIZE   = SIN_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [PHASE_RES-1:0] fcw,
  input  logic                 fcw_ld,
  input  logic                 phase_clr,
  output logic [SIN_SIZE-1:0]  sin_out,
`ifdef COS_OUT_EN
  output logic [SIN_SIZE-1:0]  cos_out,
`endif
  output logic                 out_valid
);

  localparam int MAG_W  = SIN_SIZE - 1;
  localparam int ADDR_W = LUT_ADDR_W + 1;

  function automatic logic [ADDR_W-1:0] fold_addr(quad_e q, logic [LUT_ADDR_W-1:0] i);
    logic [ADDR_W-1:0] full;
    full = {1'b1, {LUT_ADDR_W{1'b0}}};
    return quad_mirrored(q) ? (full - {1'b0, i}) : {1'b0, i};
  endfunction

  // A zero magnitude is never emitted with the sign bit set.
  function automatic logic [SIN_SIZE-1:0] sign_mag(logic neg, logic [MAG_W-1:0] mag);
    return {neg && (mag != '0), mag};
  endfunction

  logic [PHASE_RES-1:0]  acc_q, acc_d, fcw_q, fcw_d, phase;
  quad_e                 quad;
  logic [LUT_ADDR_W-1:0] idx;

  assign phase = phase_clr ? '0 : acc_q;
  assign quad  = quad_e'(phase[PHASE_RES-1 -: 2]);
  assign idx   = phase[PHASE_RES-3 -: LUT_ADDR_W];

  always_comb begin
    acc_d = acc_q;
    fcw_d = fcw_q;
    if (en)             acc_d = phase + fcw_q;
    else if (phase_clr) acc_d = '0;
    if (fcw_ld)         fcw_d = fcw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      fcw_q <= '0;
    end else begin
      acc_q <= acc_d;
      fcw_q <= fcw_d;
    end
  end

  logic [ADDR_W-1:0] s1_sin_addr_q;
  logic              s1_sin_neg_q, s1_vld_q;
  logic              s2_sin_neg_q, s2_vld_q;
  logic [MAG_W-1:0]  sin_mag;

  always_ff @(posedge clk) begin
    s1_sin_addr_q <= fold_addr(quad, idx);
    s1_sin_neg_q  <= quad_negative(quad);
    s2_sin_neg_q  <= s1_sin_neg_q;
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      out_valid <= 1'b0;
      sin_out   <= '0;
    end else begin
      s1_vld_q  <= en;
      s2_vld_q  <= s1_vld_q;
      out_valid <= s2_vld_q;
      if (s2_vld_q) sin_out <= sign_mag(s2_sin_neg_q, sin_mag);
    end
  end

`ifdef COS_OUT_EN
  logic [1:0]        cos_quad_raw;
  quad_e             cos_quad;
  logic [ADDR_W-1:0] s1_cos_addr_q;
  logic              s1_cos_neg_q, s2_cos_neg_q;
  logic [MAG_W-1:0]  cos_mag;

  // Cosine is the sine one quadrant ahead.
  assign cos_quad_raw = phase[PHASE_RES-1 -: 2] + 2'd1;
  assign cos_quad     = quad_e'(cos_quad_raw);

  always_ff @(posedge clk) begin
    s1_cos_addr_q <= fold_addr(cos_quad, idx);
    s1_cos_neg_q  <= quad_negative(cos_quad);
    s2_cos_neg_q  <= s1_cos_neg_q;
    if (rst)           cos_out <= '0;
    else if (s2_vld_q) cos_out <= sign_mag(s2_cos_neg_q, cos_mag);
  end
`endif

  sin_quarter_rom #(
    .LUT_ADDR_W (LUT_ADDR_W),
    .MAG_W      (MAG_W)
  ) u_rom (
    .clk    (clk),
    .addr_a (s1_sin_addr_q),
    .data_a (sin_mag)
`ifdef COS_OUT_EN
    ,
    .addr_b (s1_cos_addr_q),
    .data_b (cos_mag)
`endif
  );

endmodule

// File: tb/tb_nco_sin_gen.sv
// tb/tb_nco_sin_gen.sv - directed bench for nco_sin_gen at PHASE_RES=3, LUT_ADDR_W=1, SIN_SIZE=13
module tb_nco_sin_gen;

  localparam int PR = 3;
  localparam int LA = 1;
  localparam int SS = 13;

  logic          clk = 1'b0;
  logic          rst, en, fcw_ld, phase_clr;
  logic [PR-1:0] fcw;
  logic [SS-1:0] sin_out;
  logic          out_valid;
`ifdef COS_OUT_EN
  logic [SS-1:0] cos_out;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int hold_err = 0;
  int start;

  logic [SS-1:0] cap_sin[$];
  logic [SS-1:0] cap_cos[$];
  int            cap_cyc[$];
  logic [SS-1:0] exp_q[$];
  logic [SS-1:0] last_sin = '0;
  logic          rst_prev = 1'b1;

  nco_sin_gen #(
    .PHASE_RES  (PR),
    .LUT_ADDR_W (LA),
    .SIN_SIZE   (SS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fcw       (fcw),
    .fcw_ld    (fcw_ld),
    .phase_clr (phase_clr),
    .sin_out   (sin_out),
`ifdef COS_OUT_EN
    .cos_out   (cos_out),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every valid sample; between samples the outputs must hold.
  always @(negedge clk) begin
    if (out_valid) begin
      cap_sin.push_back(sin_out);
      cap_cyc.push_back(cyc);
`ifdef COS_OUT_EN
      cap_cos.push_back(cos_out);
`endif
      last_sin = sin_out;
    end else if (rst || rst_prev) begin
      last_sin = sin_out;
    end else if (sin_out !== last_sin) begin
      hold_err++;
    end
    rst_prev = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_seq(string tag);
    check({tag, "_count"}, cap_sin.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_sin.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(cap_sin[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_caps();
    cap_sin.delete();
    cap_cos.delete();
    cap_cyc.delete();
  endtask

  task automatic run_en(int n);
    en = 1'b1;
    repeat (n) tick();
    en = 1'b0;
  endtask

  int offs[4] = '{0, 2, 5, 6};
  int pat[7]  = '{1, 0, 1, 0, 0, 1, 1};

  initial begin
    rst = 1'b1; en = 1'b0; fcw_ld = 1'b0; phase_clr = 1'b0; fcw = '0;
    repeat (3) tick();
    check("rst_sin", 32'(sin_out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;

    // fcw=1 sweep through every phase
    fcw_ld = 1'b1; fcw = 3'd1; tick(); fcw_ld = 1'b0;
    clear_caps();
    start = cyc;
    run_en(8);
    repeat (5) tick();
    exp_q = '{13'h0000, 13'h0B50, 13'h0FFF, 13'h0B50, 13'h0000, 13'h1B50, 13'h1FFF, 13'h1B50};
    check_seq("fcw1");
    check("fcw1_latency", (cap_cyc.size() > 0) ? cap_cyc[0] - start : -1, 32'd3);
    check("fcw1_no_bubble", (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] - cap_cyc[0] : -1, 32'd7);

    // fcw=3 wraps modulo 8
    fcw_ld = 1'b1; fcw = 3'd3; tick(); fcw_ld = 1'b0;
    clear_caps();
    run_en(8);
    repeat (5) tick();
    exp_q = '{13'h0000, 13'h0B50, 13'h1FFF, 13'h0B50, 13'h0000, 13'h1B50, 13'h0FFF, 13'h1B50};
    check_seq("fcw3");

    // phase_clr with en at phase 5, then next phase = fcw_reg
    clear_caps();
    for (int i = 0; i < 9; i++) begin
      en = 1'b1;
      phase_clr = (i == 7);
      tick();
    end
    en = 1'b0; phase_clr = 1'b0;
    repeat (5) tick();
    exp_q = '{13'h0000, 13'h0B50, 13'h1FFF, 13'h0B50, 13'h0000, 13'h1B50, 13'h0FFF, 13'h0000, 13'h0B50};
    check_seq("clr_en");

    // phase_clr alone zeroes the accumulator (acc was 6)
    phase_clr = 1'b1; tick(); phase_clr = 1'b0;
    clear_caps();
    run_en(1);
    repeat (5) tick();
    exp_q = '{13'h0000};
    check_seq("clr_alone");

    // fcw reload 2->1 in an en cycle, with en gaps
    fcw_ld = 1'b1; fcw = 3'd2; tick(); fcw_ld = 1'b0;
    phase_clr = 1'b1; tick(); phase_clr = 1'b0;
    clear_caps();
    start = cyc;
    for (int i = 0; i < 7; i++) begin
      en = pat[i][0];
      fcw_ld = (i == 0);
      fcw = 3'd1;
      tick();
    end
    en = 1'b0; fcw_ld = 1'b0;
    repeat (5) tick();
    exp_q = '{13'h0000, 13'h0FFF, 13'h0B50, 13'h0000};
    check_seq("fcw_reload");
    for (int k = 0; k < 4; k++)
      check($sformatf("gap_cycle[%0d]", k), (k < cap_cyc.size()) ? cap_cyc[k] - start : -1, 32'(3 + offs[k]));

    // acc=5, fcw=1: two samples, then reset with two more in flight
    clear_caps();
    run_en(2);
    repeat (5) tick();
    exp_q = '{13'h1B50, 13'h1FFF};
    check_seq("pre_rst");
    clear_caps();
    run_en(2);
    rst = 1'b1; fcw_ld = 1'b1; fcw = 3'd5; phase_clr = 1'b1;
    tick();
    rst = 1'b0; fcw_ld = 1'b0; phase_clr = 1'b0;
    check("flush_sin", 32'(sin_out), 32'h0);
    check("flush_valid", 32'(out_valid), 32'h0);
    repeat (5) tick();
    check("flush_no_valid", cap_sin.size(), 32'd0);

    // after reset: acc=0 and fcw_reg=0, so every sample is phase 0
    clear_caps();
    run_en(2);
    repeat (5) tick();
    exp_q = '{13'h0000, 13'h0000};
    check_seq("post_rst");

    check("hold_between_samples", hold_err, 32'd0);

`ifdef COS_OUT_EN
    fcw_ld = 1'b1; fcw = 3'd2; tick(); fcw_ld = 1'b0;
    clear_caps();
    run_en(4);
    repeat (5) tick();
    exp_q = '{13'h0000, 13'h0FFF, 13'h0000, 13'h1FFF};
    check_seq("cos_sin");
    exp_q = '{13'h0FFF, 13'h0000, 13'h1FFF, 13'h0000};
    check("cos_count", cap_cos.size(), 32'd4);
    for (int i = 0; i < 4 && i < cap_cos.size(); i++)
      check($sformatf("cos[%0d]", i), 32'(cap_cos[i]), 32'(exp_q[i]));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
